// File: rtl/mfcc_common_pkg.sv
// Shared types and default widths for the MFCC front-end framing blocks.
package mfcc_common_pkg;

    localparam int unsigned COUNTER_VALUE_WIDTH_DEF = 8;
    localparam int unsigned FRAME_CNT_WIDTH_DEF     = 8;
    localparam int unsigned DATA_WIDTH_DEF          = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } frame_state_e;

endpackage

// File: rtl/frame_idx_counter.sv
// Up-counter that wraps to zero after reaching a terminal value; wrap is flagged
// combinationally in the cycle the wrapping increment is taken.
module frame_idx_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic             wrap,
    output logic [WIDTH-1:0] count
);

    assign wrap = en && (count == term);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/frame_ctrl.sv
// Splits an input sample stream into runs of frames, tagging each sample with its
// sample/frame index and sof/eof. Define FRAME_CTRL_ERR_EN to add the sticky err output.
module frame_ctrl
    import mfcc_common_pkg::*;
#(
    parameter int unsigned COUNTER_VALUE_WIDTH = COUNTER_VALUE_WIDTH_DEF,
    parameter int unsigned FRAME_CNT_WIDTH     = FRAME_CNT_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH          = DATA_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [COUNTER_VALUE_WIDTH-1:0] frame_len,
    input  logic [FRAME_CNT_WIDTH-1:0]     frame_num,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [COUNTER_VALUE_WIDTH-1:0] out_sample_idx,
    output logic [FRAME_CNT_WIDTH-1:0]     out_frame_idx,
    output logic                           out_sof,
    output logic                           out_eof,
    output logic                           busy,
    output logic                           done
`ifdef FRAME_CTRL_ERR_EN
    ,
    output logic                           err
`endif
);

    frame_state_e state_q, state_d;

    logic [COUNTER_VALUE_WIDTH-1:0] len_q;
    logic [FRAME_CNT_WIDTH-1:0]     num_q;
    logic [COUNTER_VALUE_WIDTH-1:0] s_cnt;
    logic [FRAME_CNT_WIDTH-1:0]     f_cnt;
    logic s_wrap, f_wrap;
    logic start_acc, accept, xfer, cnt_rst;

    assign in_ready  = (state_q == StRun) && (!out_valid || out_ready);
    assign start_acc = (state_q == StIdle) && start && !abort;
    // abort outranks the handshake even though in_ready may be high this cycle
    assign accept    = in_valid && in_ready && !abort;
    assign xfer      = out_valid && out_ready;
    assign cnt_rst   = rst || abort || start_acc;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

    frame_idx_counter #(
        .WIDTH(COUNTER_VALUE_WIDTH)
    ) u_sample_cnt (
        .clk  (clk),
        .rst  (cnt_rst),
        .en   (accept),
        .term (len_q),
        .wrap (s_wrap),
        .count(s_cnt)
    );

    // f_wrap marks acceptance of the final sample of the run
    frame_idx_counter #(
        .WIDTH(FRAME_CNT_WIDTH)
    ) u_frame_cnt (
        .clk  (clk),
        .rst  (cnt_rst),
        .en   (s_wrap),
        .term (num_q),
        .wrap (f_wrap),
        .count(f_cnt)
    );

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start)  state_d = StRun;
                StRun:   if (f_wrap) state_d = StDrain;
                StDrain: if (xfer)   state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_sample_idx <= '0;
            out_frame_idx  <= '0;
            out_sof        <= 1'b0;
            out_eof        <= 1'b0;
            len_q          <= '0;
            num_q          <= '0;
        end else begin
            if (abort) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid      <= 1'b1;
                out_data       <= in_data;
                out_sample_idx <= s_cnt;
                out_frame_idx  <= f_cnt;
                out_sof        <= (s_cnt == '0);
                out_eof        <= (s_cnt == len_q);
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            if (start_acc) begin
                len_q <= frame_len;
                num_q <= frame_num;
            end
        end
    end

`ifdef FRAME_CTRL_ERR_EN
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            err <= 1'b0;
        end else if (in_valid && (state_q != StRun)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_ctrl.sv
// Randomized bench for frame_ctrl against a stream-level framing model.
// Define FRAME_CTRL_ERR_EN to also exercise the err output.
module tb_frame_ctrl;

    localparam int CW = 8;
    localparam int FW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] frame_len = '0;
    logic [FW-1:0] frame_num = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_sample_idx;
    logic [FW-1:0] out_frame_idx;
    logic          out_sof, out_eof, busy, done;
`ifdef FRAME_CTRL_ERR_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    frame_ctrl #(
        .COUNTER_VALUE_WIDTH(CW),
        .FRAME_CNT_WIDTH    (FW),
        .DATA_WIDTH         (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .frame_len     (frame_len),
        .frame_num     (frame_num),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_sample_idx(out_sample_idx),
        .out_frame_idx (out_frame_idx),
        .out_sof       (out_sof),
        .out_eof       (out_eof),
        .busy          (busy),
        .done          (done)
`ifdef FRAME_CTRL_ERR_EN
        ,
        .err           (err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_data [256];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // mode: 0 ready, 1 3-cycle stall, 2 random, 3 abort after 5 accepts, 4 rst in drain
    task automatic run_frame(input int len, input int num, input int mode);
        int total = (len + 1) * (num + 1);
        int sent = 0, recv = 0, done_cnt = 0, last_xfer = -10, cyc = 0;
        bit prev_stall = 0, finished = 0, cut = 0;
        logic [DW-1:0] prev_data = '0;
        logic [CW-1:0] prev_sidx = '0;
        for (int i = 0; i < total; i++) exp_data[i] = DW'($urandom);

        start = 1; frame_len = CW'(len); frame_num = FW'(num);
        in_valid = 1; in_data = 16'hdead; out_ready = 1;
        @(negedge clk);
        check_eq("idle_in_ready", in_ready, 0);
        check_eq("idle_busy", busy, 0);
        @(posedge clk); #1;
        start = 0; frame_len = CW'($urandom); frame_num = FW'($urandom);
        check_eq("run_busy", busy, 1);

        while (!finished && cyc < 400) begin
            in_valid = (sent < total) && (mode != 2 || $urandom_range(3) != 0);
            in_data  = (sent < total) ? exp_data[sent] : '0;
            case (mode)
                1:       out_ready = !(cyc >= 3 && cyc < 6);
                2:       out_ready = ($urandom_range(3) != 0);
                4:       out_ready = (sent < total);
                default: out_ready = 1;
            endcase
            abort = (mode == 3 && sent == 5);
            rst   = (mode == 4 && sent == total && recv == total - 1);
            @(negedge clk);
            if (abort || rst) begin
                @(posedge clk); #1;
                abort = 0; rst = 0; in_valid = 0; out_ready = 1;
                @(negedge clk);
                check_eq("cut_out_valid", out_valid, 0);
                check_eq("cut_busy", busy, 0);
                check_eq("cut_done", done, 0);
                check_eq("cut_in_ready", in_ready, 0);
                if (mode == 4) begin
                    check_eq("rst_sof", out_sof, 0);
                    check_eq("rst_eof", out_eof, 0);
                    check_eq("rst_sidx", out_sample_idx, 0);
                    check_eq("rst_fidx", out_frame_idx, 0);
                    check_eq("rst_data", out_data, 0);
                end
                @(posedge clk); #1;
                check_eq("cut_done_later", done, 0);
                finished = 1;
                cut = 1;
            end else begin
                if (prev_stall) begin
                    check_eq("hold_valid", out_valid, 1);
                    check_eq("hold_data", out_data, prev_data);
                    check_eq("hold_sidx", out_sample_idx, prev_sidx);
                end
                check_eq("in_ready", in_ready, (sent < total) && (!out_valid || out_ready));
                if (in_valid && in_ready) sent++;
                if (out_valid && out_ready) begin
                    check_eq("out_data", out_data, exp_data[recv]);
                    check_eq("out_sidx", out_sample_idx, recv % (len + 1));
                    check_eq("out_fidx", out_frame_idx, recv / (len + 1));
                    check_eq("out_sof", out_sof, (recv % (len + 1)) == 0);
                    check_eq("out_eof", out_eof, (recv % (len + 1)) == len);
                    recv++;
                    if (recv == total) last_xfer = cyc;
                end
                if (done) begin
                    done_cnt++;
                    check_eq("done_latency", cyc, last_xfer + 1);
                end
                if (recv == total && cyc == last_xfer + 3) begin
                    check_eq("end_busy", busy, 0);
                    finished = 1;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_sidx  = out_sample_idx;
                @(posedge clk); #1;
                cyc++;
            end
        end
        check_eq("finished", finished, 1);
        if (cut) begin
            check_eq("no_done", done_cnt, 0);
        end else begin
            check_eq("out_count", recv, total);
            check_eq("done_count", done_cnt, 1);
        end
        in_valid = 0;
    endtask

    initial begin
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_idx", {out_sample_idx, out_frame_idx}, 0);
        @(posedge clk); #1;

        run_frame(3, 1, 0);
        run_frame(3, 1, 1);
        run_frame(0, 2, 0);
        run_frame(3, 1, 3);
        run_frame(3, 1, 0);
        for (int k = 0; k < 4; k++) begin
            run_frame(int'($urandom_range(4)), int'($urandom_range(3)), 2);
        end
        run_frame(1, 1, 4);
        run_frame(2, 0, 0);

`ifdef FRAME_CTRL_ERR_EN
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        check_eq("err_set", err, 1);
        @(posedge clk); #1;
        check_eq("err_held", err, 1);
        start = 1; frame_len = '0; frame_num = '0;
        @(posedge clk); #1;
        start = 0;
        check_eq("err_clr", err, 0);
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        check_eq("err_abort_idle", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_ctrl.md
FRAME_CTRL -- requirements
Module: frame_ctrl

Interface
REQ-001 The block SHALL have parameter COUNTER_VALUE_WIDTH, default 8, giving the sample-index and frame-length width.
REQ-002 The block SHALL have parameter FRAME_CNT_WIDTH, default 8, giving the frame-index and frame-count width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 16, giving the sample data width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin a framing run; sampled only in IDLE.
REQ-007 abort  in  1  cancel the run; return to IDLE.
REQ-008 frame_len  in  COUNTER_VALUE_WIDTH  samples per frame minus one; latched on start.
REQ-009 frame_num  in  FRAME_CNT_WIDTH  frames per run minus one; latched on start.
REQ-010 in_valid / in_ready  in / out  1 / 1  upstream sample handshake.
REQ-011 in_data  in  DATA_WIDTH  sample data.
REQ-012 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-013 out_data  out  DATA_WIDTH  registered sample data.
REQ-014 out_sample_idx  out  COUNTER_VALUE_WIDTH  position of out_data within its frame.
REQ-015 out_frame_idx  out  FRAME_CNT_WIDTH  frame number of out_data.
REQ-016 out_sof / out_eof  out / out  1 / 1  first / last sample of a frame, qualified by out_valid.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse at the end of the run.

Function
REQ-019 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-020 IDLE->RUN on start; this latches frame_len and frame_num and clears both indices to 0.
REQ-021 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready); it SHALL be low in IDLE, DRAIN and DONE.
REQ-022 An accepted sample (in_valid && in_ready) SHALL load out_data, the indices, out_sof and out_eof, and SHALL set out_valid on the next edge, giving a latency of 1 cycle.
REQ-023 out_valid SHALL clear after an output transfer (out_valid && out_ready) that has no concurrent acceptance.
REQ-024 Output registers SHALL hold stable while out_valid && !out_ready.
REQ-025 The sample counter SHALL increment per accepted sample and wrap to 0 after reaching frame_len, so each frame has frame_len+1 samples.
REQ-026 The frame counter SHALL increment whenever the sample counter wraps.
REQ-027 out_sof SHALL be 1 when out_sample_idx==0, and out_eof SHALL be 1 when out_sample_idx==latched frame_len.
REQ-028 When frame_len==0, each sample SHALL assert both out_sof and out_eof.
REQ-029 Accepting the sample at sample==frame_len and frame==frame_num SHALL move RUN->DRAIN.
REQ-030 DRAIN->DONE SHALL occur on the output transfer of that last sample.
REQ-031 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-032 abort in any state SHALL force IDLE, clear out_valid and clear both counters on the next edge.
REQ-033 abort SHALL take priority over start and over any handshake in the same cycle.
REQ-034 start SHALL be ignored outside IDLE, and latched parameters SHALL not change mid-run.
REQ-035 start and in_valid asserted together in IDLE SHALL not accept a sample in that cycle.

Reset
REQ-036 rst SHALL force state IDLE, out_valid=0, out_sof=0, out_eof=0, done=0, busy=0, in_ready=0, zero indices, out_data=0 and zero latched parameters.
REQ-037 rst asserted mid-run SHALL discard any pending output with no done pulse.

Configuration
REQ-038 The macro FRAME_CTRL_ERR_EN SHALL control a status feature.
REQ-039 With FRAME_CTRL_ERR_EN defined, output err (1 bit) SHALL go sticky high when in_valid is high in IDLE, DRAIN or DONE, and SHALL clear on rst or on an accepted start.
REQ-040 Without FRAME_CTRL_ERR_EN, the err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-041 The FSM state enum (2-bit encoding) and the default widths SHALL reside in the shared package mfcc_common_pkg.
REQ-042 The per-frame sample counter SHALL be one sub-module, frame_idx_counter: enable, terminal value, wrap flag, count output, synchronous active-high reset.
REQ-043 The frame counter SHALL be a second instance of frame_idx_counter, enabled by the sample wrap.

Verification
REQ-044 frame_len=3, frame_num=1, continuous in_valid, out_ready=1 -> 8 outputs, sample_idx 0,1,2,3,0,1,2,3, frame_idx 0×4 then 1×4, sof at idx0, eof at idx3, done once, 1 cycle after the last transfer.
REQ-045 Same run with out_ready low for 3 cycles mid-frame -> in_ready low, outputs held stable, no loss or duplication, 8 outputs total.
REQ-046 frame_len=0, frame_num=2 -> 3 outputs, each with sof=eof=1, frame_idx 0,1,2.
REQ-047 abort on the 5th sample of the REQ-044 run -> next cycle IDLE, out_valid=0, no done; a new start then begins at idx 0/0.
REQ-048 rst during DRAIN -> all outputs at reset values next cycle, no done pulse.
REQ-049 With FRAME_CTRL_ERR_EN defined, in_valid=1 in IDLE -> err=1 and held; a following start -> err=0.
